// File: rtl/neopixel_strip_ctrl_if.sv
// iomem peripheral bus between the picosoc core (master) and the strip controller (slave).
interface neopixel_strip_ctrl_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   input  iomem_ready, iomem_rdata);
   modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   output iomem_ready, iomem_rdata);
endinterface

// File: rtl/neopixel_strip_ctrl.sv
// Frame sequencer: bus-writable pixel buffer streamed pixel by pixel into the
// single-pixel neopixel driver, followed by a latch-time idle period.
module neopixel_strip_ctrl #(
   parameter logic [31:0] BASE_ADDR    = 32'h0500_0000,
   parameter int          NUM_PIXELS   = 64,
   parameter int          LATCH_CYCLES = 1000
) (
   input  logic                        clk,
   input  logic                        resetn,
   neopixel_strip_ctrl_if.slave        bus,
   output logic [23:0]                 neo_data,
   output logic                        neo_start,
   input  logic                        neo_busy,
   output logic                        frame_irq
);

   localparam int            AW       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int            CW       = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [8:0]    NP       = 9'(NUM_PIXELS);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATCH_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WHI, S_WLO, S_LATCH} state_e;

   state_e          state_q;
   logic [7:0]      idx_q;
   logic [CW-1:0]   cnt_q;
   logic [8:0]      len_q, len_d;
   logic            done_q;
   logic            ready_q, ready_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [23:0]     neo_data_q;
   logic            neo_start_q, frame_irq_q;
   logic [23:0]     pix_mem [2**AW];

   logic            busy, acc, is_wr, sel_ctrl, sel_len, sel_pix, pix_ok;
   logic            start_req, clr_req;
   logic [7:0]      pidx;
   logic [8:0]      len_wr;

   always_comb begin
      busy      = (state_q != S_IDLE);
      acc       = bus.iomem_valid & ~ready_q & (bus.iomem_addr[31:12] == BASE_ADDR[31:12]);
      is_wr     = |bus.iomem_wstrb;
      sel_ctrl  = (bus.iomem_addr[11:2] == 10'h000);
      sel_len   = (bus.iomem_addr[11:2] == 10'h001);
      sel_pix   = (bus.iomem_addr[11:10] == 2'b01);
      pidx      = bus.iomem_addr[9:2];
      pix_ok    = sel_pix & ({1'b0, pidx} < NP);
      start_req = acc & is_wr & sel_ctrl & bus.iomem_wstrb[0] & bus.iomem_wdata[0];
      clr_req   = acc & is_wr & sel_ctrl & bus.iomem_wstrb[0] & bus.iomem_wdata[1];

      len_wr = len_q;
      if (bus.iomem_wstrb[0]) len_wr[7:0] = bus.iomem_wdata[7:0];
      if (bus.iomem_wstrb[1]) len_wr[8]   = bus.iomem_wdata[8];
      len_d = len_q;
      if (acc & is_wr & sel_len & ~busy) len_d = (len_wr > NP) ? NP : len_wr;

      ready_d = acc;
      rdata_d = '0;
      if (acc & ~is_wr) begin
         if (sel_ctrl)     rdata_d = {30'b0, done_q, busy};
         else if (sel_len) rdata_d = {23'b0, len_q};
         else if (pix_ok)  rdata_d = {8'b0, pix_mem[pidx[AW-1:0]]};
      end
   end

   // Pixels are 24-bit, so byte lane 3 has no storage behind it.
   always_ff @(posedge clk) begin
      if (resetn && acc && is_wr && pix_ok) begin
         for (int b = 0; b < 3; b++)
            if (bus.iomem_wstrb[b]) pix_mem[pidx[AW-1:0]][8*b +: 8] <= bus.iomem_wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         len_q       <= NP;
         done_q      <= 1'b0;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         neo_data_q  <= '0;
         neo_start_q <= 1'b0;
         frame_irq_q <= 1'b0;
      end else begin
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         len_q       <= len_d;
         neo_start_q <= 1'b0;
         frame_irq_q <= 1'b0;
         if (clr_req) done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start_req && len_q != '0) begin
               state_q <= S_LOAD;
               idx_q   <= '0;
               done_q  <= 1'b0;
            end
            // neo_start_q rises with the move to KICK, so the pulse covers exactly KICK.
            S_LOAD: begin
               neo_data_q  <= pix_mem[idx_q[AW-1:0]];
               neo_start_q <= 1'b1;
               state_q     <= S_KICK;
            end
            S_KICK: state_q <= S_WHI;
            S_WHI:  if (neo_busy) state_q <= S_WLO;
            S_WLO:  if (!neo_busy) begin
               if ({1'b0, idx_q} == len_q - 9'd1) begin
                  state_q <= S_LATCH;
                  cnt_q   <= CNT_INIT;
               end else begin
                  idx_q   <= idx_q + 8'd1;
                  state_q <= S_LOAD;
               end
            end
            S_LATCH: if (cnt_q == '0) begin
               state_q     <= S_IDLE;
               done_q      <= 1'b1;
               frame_irq_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
   assign neo_data        = neo_data_q;
   assign neo_start       = neo_start_q;
   assign frame_irq       = frame_irq_q;

   logic unused_ok;
   assign unused_ok = ^{bus.iomem_addr[1:0], bus.iomem_wdata[31:24]};

endmodule
